// File: rtl/alu_muldiv_controller.sv
// ALU operation decode for the base integer ISA plus an iterative (one bit per cycle)
// multiply/divide engine for the M extension, with a stall/valid handshake to execute.
module alu_muldiv_controller #(
  parameter int WIDTH     = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic             RType,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic [3:0]       Operation,
  output logic             op_illegal,
  output logic             md_sel,
  output logic             md_busy,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_result
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_SUB  = 4'b0011, OP_XOR  = 4'b0100, OP_SLL  = 4'b0101,
                         OP_SRL  = 4'b0110, OP_SRA  = 4'b0111, OP_BEQ  = 4'b1000,
                         OP_BNE  = 4'b1001, OP_BLT  = 4'b1010, OP_BGE  = 4'b1011,
                         OP_SLT  = 4'b1100, OP_SLTU = 4'b1101, OP_BLTU = 4'b1110,
                         OP_BGEU = 4'b1111;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   md_result_q;
  logic               md_valid_q;

  // ---------------- decode ----------------
  logic [3:0] base_op;
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       dec_m;

  always_comb begin
    case (Funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    case (ALUOp)
      2'b01: begin
        case (Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (RType) begin
          if (Funct7 == 7'b0000000) begin
            dec_op = base_op;
          end else if (Funct7 == 7'b0100000 && Funct3 == 3'b000) begin
            dec_op = OP_SUB;
          end else if (Funct7 == 7'b0100000 && Funct3 == 3'b101) begin
            dec_op = OP_SRA;
          end else if (Funct7 == 7'b0000001) begin
            if (EN_MULDIV) dec_m = 1'b1;
            else           dec_ill = 1'b1;
          end else begin
            dec_ill = 1'b1;
          end
        end else begin
          // I-type: Funct7 bits are immediate except for the shift encodings
          dec_op = base_op;
          if (Funct3 == 3'b001 && Funct7 != 7'b0000000) begin
            dec_ill = 1'b1;
          end else if (Funct3 == 3'b101) begin
            if (Funct7 == 7'b0100000)      dec_op = OP_SRA;
            else if (Funct7 != 7'b0000000) dec_ill = 1'b1;
          end
        end
      end
      default: dec_op = OP_ADD;
    endcase
  end

  assign op_illegal = dec_ill;
  assign Operation  = dec_ill ? OP_ADD : dec_op;
  assign md_sel     = dec_m;

  logic md_req;
  assign md_req = Valid & md_sel & EN_MULDIV & ~flush;

  // ---------------- operand capture ----------------
  logic             signed_a, signed_b, sign_a, sign_b, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  always_comb begin
    signed_a    = !(Funct3 == 3'b011 || Funct3 == 3'b101 || Funct3 == 3'b111);
    signed_b    = signed_a && (Funct3 != 3'b010);
    sign_a      = signed_a & SrcA[WIDTH-1];
    sign_b      = signed_b & SrcB[WIDTH-1];
    mag_a       = sign_a ? -SrcA : SrcA;
    mag_b       = sign_b ? -SrcB : SrcB;
    is_div      = Funct3[2];
    div_zero    = is_div && (SrcB == '0);
    div_ovf     = is_div && !Funct3[0] && (SrcA == MIN_VAL) && (SrcB == ONES);
    special_res = div_zero ? (Funct3[1] ? SrcA : ONES) : (Funct3[1] ? '0 : MIN_VAL);
  end

  // ---------------- iteration step ----------------
  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step_acc;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (div_diff[WIDTH]) step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
      else                 step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fix_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      md_result_q <= '0;
      md_valid_q  <= 1'b0;
    end else begin
      md_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_req) begin
            op_q      <= Funct3;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            count_q   <= CW'(WIDTH - 1);
            opnd_q    <= is_div ? mag_b : mag_a;
            acc_q     <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            if (div_zero || div_ovf) begin
              md_result_q <= special_res;
              md_valid_q  <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= step_acc;
            count_q <= count_q - CW'(1);
            if (count_q == '0) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            md_result_q <= fix_res;
            md_valid_q  <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_busy   = (state_q == S_IDLE && md_req) || state_q == S_CALC || state_q == S_FIX;
  // a flush arriving in DONE squashes the writeback pulse of the aborted instruction
  assign md_valid  = md_valid_q & ~flush;
  assign md_result = md_result_q;

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Self-checking bench: decode sweep against a rule-based model, and mul/div
// transactions (directed + random) against 64-bit arithmetic reference results.
module tb_alu_muldiv_controller;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Valid, RType, flush;
  logic [1:0]    ALUOp;
  logic [6:0]    Funct7;
  logic [2:0]    Funct3;
  logic [W-1:0]  SrcA, SrcB;
  logic [3:0]    Operation, Operation0;
  logic          op_illegal, md_sel, md_busy, md_valid;
  logic          op_illegal0, md_sel0, md_busy0, md_valid0;
  logic [W-1:0]  md_result, md_result0;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_controller #(.WIDTH(W), .EN_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .RType(RType), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
    .Operation(Operation), .op_illegal(op_illegal), .md_sel(md_sel),
    .md_busy(md_busy), .md_valid(md_valid), .md_result(md_result)
  );

  alu_muldiv_controller #(.WIDTH(W), .EN_MULDIV(1'b0)) dut_nomd (
    .clk(clk), .reset(reset), .Valid(Valid), .RType(RType), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
    .Operation(Operation0), .op_illegal(op_illegal0), .md_sel(md_sel0),
    .md_busy(md_busy0), .md_valid(md_valid0), .md_result(md_result0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {op_illegal, md_sel, Operation}
  function automatic logic [5:0] dec_ref(input logic [1:0] aop, input logic rt,
                                         input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] base, op;
    logic       ill, sel;
    case (f3)
      3'd0: base = 4'h2;  3'd1: base = 4'h5;  3'd2: base = 4'hC;  3'd3: base = 4'hD;
      3'd4: base = 4'h4;  3'd5: base = 4'h6;  3'd6: base = 4'h1;  default: base = 4'h0;
    endcase
    op = 4'h2; ill = 1'b0; sel = 1'b0;
    if (aop == 2'b01) begin
      case (f3)
        3'd0: op = 4'h8;  3'd1: op = 4'h9;  3'd4: op = 4'hA;
        3'd5: op = 4'hB;  3'd6: op = 4'hE;  3'd7: op = 4'hF;
        default: ill = 1'b1;
      endcase
    end else if (aop == 2'b10 && rt) begin
      if (f7 == 7'h00)                   op = base;
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4'h3;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 4'h7;
      else if (f7 == 7'h01)              sel = 1'b1;
      else                               ill = 1'b1;
    end else if (aop == 2'b10) begin
      op = base;
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      if (f3 == 3'd5 && f7 == 7'h20) op = 4'h7;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
    end
    if (ill) op = 4'h2;
    return {ill, sel, op};
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic set_dec(input logic [1:0] aop, input logic rt, input logic [6:0] f7,
                         input logic [2:0] f3);
    ALUOp = aop; RType = rt; Funct7 = f7; Funct3 = f3;
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge following DONE.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat, busy_n, vat;
    exp = md_ref(f3, a, b);
    lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : W + 2;
    Valid = 1'b1; RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3;
    SrcA = a; SrcB = b; flush = 1'b0;
    #1;
    check("md_sel", md_sel, 1'b1);
    check("md_op_add", Operation, 4'h2);
    busy_n = 0; vat = -1;
    for (int i = 0; i < 100; i++) begin
      if (md_valid) begin vat = i; break; end
      if (md_busy) busy_n++;
      @(posedge clk); #1;
    end
    check("md_valid_latency", vat, lat);
    check("md_busy_cycles", busy_n, lat);
    check("md_busy_in_done", md_busy, 1'b0);
    check("md_result", md_result, exp);
    $display("md f3=%0d a=%h b=%h result=%h exp=%h valid_at=%0d busy=%0d",
             f3, a, b, md_result, exp, vat, busy_n);
    Valid = 1'b0;
    @(posedge clk); #1;
    check("md_valid_pulse", md_valid, 1'b0);
    check("md_result_hold", md_result, exp);
  endtask

  initial begin
    logic [31:0] prev_res, ra, rb;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    int          pulses;

    reset = 1'b1; Valid = 1'b0; RType = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    SrcA = '0; SrcB = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", md_busy, 1'b0);
    check("rst_valid", md_valid, 1'b0);
    check("rst_result", md_result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed decode points
    set_dec(2'b10, 1'b0, 7'h01, 3'd0);
    check("addi_imm", {op_illegal, md_sel, md_busy, Operation}, {3'b000, 4'h2});
    set_dec(2'b10, 1'b0, 7'h20, 3'd5);
    check("srai", {op_illegal, Operation}, {1'b0, 4'h7});
    set_dec(2'b01, 1'b0, 7'h00, 3'd3);
    check("branch_011", {op_illegal, Operation}, {1'b1, 4'h2});
    set_dec(2'b10, 1'b1, 7'h01, 3'd4);
    check("nomd_illegal", {op_illegal0, md_sel0, Operation0}, {2'b10, 4'h2});

    // random decode sweep (Valid low so no engine start)
    for (int i = 0; i < 150; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      set_dec(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rf7, rf3);
      check("decode", {op_illegal, md_sel, Operation}, dec_ref(ALUOp, RType, Funct7, Funct3));
      check("decode_busy", md_busy, 1'b0);
    end
    @(posedge clk); #1;

    // directed mul/div, back-to-back (each starts the cycle after the previous DONE)
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_md(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd5, 32'd100, 32'd7);
    run_md(3'd7, 32'd100, 32'd7);
    run_md(3'd5, 32'd5, 32'd0);
    run_md(3'd6, 32'd5, 32'd0);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // random mul/div
    for (int i = 0; i < 24; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_md(rf3, ra, rb);
    end

    // flush during CALC cycle 10
    prev_res = md_result;
    Valid = 1'b1; RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0;
    SrcA = 32'd1234; SrcB = 32'd5678;
    repeat (10) begin @(posedge clk); #1; end
    check("flush_pre_busy", md_busy, 1'b1);
    flush = 1'b1; Valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_busy", md_busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_valid) pulses++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", pulses, 0);
    check("flush_result_hold", md_result, prev_res);
    $display("flush at CALC cycle 10 pulses=%0d", pulses);

    // reset during CALC cycle 5
    Valid = 1'b1; RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd5;
    SrcA = 32'd100; SrcB = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    check("rst_pre_busy", md_busy, 1'b1);
    reset = 1'b1; Valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_outputs", {md_busy, md_valid, md_result}, {2'b00, 32'h0});
    reset = 1'b0;
    @(posedge clk); #1;
    run_md(3'd7, 32'd100, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_controller.md
Name: alu_muldiv_controller

Overview:
- Next-generation ALU control block: combinational base-ISA decode of ALUOp/Funct7/Funct3 into a 4-bit ALU operation code, extended with RV32M support.
- Contains an iterative, one-bit-per-cycle multiply/divide engine for M-extension ops, with an FSM, a cycle counter and a stall handshake.
- Sits in the execute stage beside the ALU. The pipeline freezes on md_busy and takes md_result when md_sel and md_valid are both high.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- EN_MULDIV, 1, when 0 M-ext encodings flag op_illegal, never start the engine, and md_busy stays 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Valid  input  1  instruction in execute is real (not bubble)
- RType  input  1  instruction is R-type (distinguishes Funct7 from I-type immediate bits)
- ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- Funct7  input  7  instr[31:25]
- Funct3  input  3  instr[14:12]
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- flush  input  1  synchronous abort of in-flight mul/div
- Operation  output  4  ALU op code (combinational)
- op_illegal  output  1  unsupported encoding (combinational)
- md_sel  output  1  current instruction is M-ext; writeback takes md_result
- md_busy  output  1  stall request to pipeline
- md_valid  output  1  md_result valid, single-cycle pulse
- md_result  output  WIDTH  mul/div result

Behaviour:
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111
  - BEQ 1000, BNE 1001, BLT 1010, BGE 1011, SLT 1100, SLTU 1101, BLTU 1110, BGEU 1111
- Decode:
  - ALUOp 00 or 11 → ADD.
  - ALUOp 01: Funct3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU. Funct3 010/011 → op_illegal.
  - ALUOp 10, RType=1: Funct7 0000000 → per Funct3 (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND). Funct7 0100000 allowed only with Funct3 000 (SUB) or 101 (SRA). Funct7 0000001 → M-ext, md_sel=1, Operation=ADD. Any other Funct7 → op_illegal.
  - ALUOp 10, RType=0: Funct7 ignored except Funct3 001 (must be 0000000) and 101 (0000000 SRL, 0100000 SRA; else op_illegal).
  - op_illegal forces Operation=ADD.
- md_req = Valid & md_sel & EN_MULDIV & ~flush.
- M-ext Funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE, md_req: capture operand magnitudes, result signs, op, and count=WIDTH-1.
    - Divisor=0 → DONE: quotient all ones, remainder = SrcA.
    - Signed DIV/REM with SrcA = MIN and SrcB = -1 → DONE: quotient MIN, remainder 0.
    - Otherwise → CALC.
  - CALC: one shift-add (mul) or restoring subtract (div) step per cycle. count decrements; at count==0 → FIX.
  - FIX: conditional two's-complement negation.
    - Product negated if signA^signB (signed operands only).
    - Quotient negated if signA^signB; remainder negated if signA (signed ops only).
    - Select low/high product half or quotient/remainder into md_result → DONE.
  - DONE: md_valid=1 for one cycle → IDLE unconditionally.
- md_busy = (IDLE & md_req) | CALC | FIX. It is 0 in DONE, so the pipeline advances the same cycle it captures the result.
- Latency, normal path: request cycle t0, CALC t1..tWIDTH, FIX tWIDTH+1, md_valid at tWIDTH+2. md_busy is high WIDTH+2 cycles.
- Latency, special cases: md_valid at t1; md_busy high 1 cycle.
- md_result holds its value until the next DONE; it is not cleared on IDLE.
- flush in CALC/FIX/DONE → IDLE next edge, no md_valid pulse. flush has priority over md_req.
- reset (any state) → IDLE. md_busy, md_valid = 0; md_result = 0; counter and internal registers = 0.
- Multiply uses a 2*WIDTH-bit accumulator; all arithmetic is modulo 2^WIDTH on outputs.

Test Plan:
- Decode sweep, ALUOp 10:
  - RType=0, Funct3 000, Funct7 0000001 (ADDI imm) → Operation 0010, md_sel 0, md_busy 0.
  - SRAI Funct7 0100000 → 0111.
  - Branch Funct3 011 → op_illegal=1, Operation 0010.
- MUL SrcA=7, SrcB=0xFFFFFFFD → md_busy high 34 cycles, md_valid at t34, md_result 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Special cases, each with md_valid at t1 and 1-cycle busy:
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Abort and back-to-back:
  - flush at CALC cycle 10 → IDLE next edge, no md_valid, md_busy 0.
  - reset at CALC cycle 5 → all outputs 0.
  - Back-to-back MUL then DIV → two md_valid pulses, correct results, DIV starts the cycle after DONE.
